// File: rtl/mod9_count_tracker.sv
// mod9_count_tracker: decodes steps, wraps and loads from sampled mod-MOD counter values.
// Optional MOD9_TRACK_STRICT_EN: a non-adjacent legal value is treated as a fault, not a load.
module mod9_count_tracker #(
  parameter int MOD   = 9,
  parameter int CNT_W = 4,
  parameter int NET_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    valid,
  input  logic [CNT_W-1:0]        q_in,
  output logic                    up,
  output logic                    down,
  output logic                    jump,
  output logic                    dir,
  output logic                    locked,
  output logic signed [NET_W-1:0] net,
  output logic [7:0]              wraps_up,
  output logic [7:0]              wraps_down,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W:0] L_MOD = (CNT_W+1)'(MOD);
  localparam logic [CNT_W:0] L_TOP = (CNT_W+1)'(MOD - 1);
  localparam logic signed [NET_W-1:0] L_NMAX =
    {1'b0, {(NET_W-1){1'b1}}};
  localparam logic signed [NET_W-1:0] L_NMIN =
    {1'b1, {(NET_W-1){1'b0}}};

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_prev, w_prev_nxt;
  logic                    r_up, w_up_nxt;
  logic                    r_down, w_down_nxt;
  logic                    r_jump, w_jump_nxt;
  logic                    r_dir, w_dir_nxt;
  logic signed [NET_W-1:0] r_net, w_net_nxt;
  logic [7:0]              r_wu, w_wu_nxt;
  logic [7:0]              r_wd, w_wd_nxt;
  logic                    r_err, w_err_nxt;

  logic [CNT_W:0] w_q;
  logic [CNT_W:0] w_p;
  logic [CNT_W:0] w_inc;
  logic [CNT_W:0] w_dec;
  logic           w_legal;

  // One extra bit keeps MOD == 2**CNT_W comparisons exact.
  assign w_q     = {1'b0, q_in};
  assign w_p     = {1'b0, r_prev};
  assign w_legal = (w_q < L_MOD);
  assign w_inc   = (w_p == L_TOP) ? '0 : w_p + 1'b1;
  assign w_dec   = (w_p == '0) ? L_TOP : w_p - 1'b1;

  // Next-state and next-output decode from the current sample.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_up_nxt    = 1'b0;
    w_down_nxt  = 1'b0;
    w_jump_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_net_nxt   = r_net;
    w_wu_nxt    = r_wu;
    w_wd_nxt    = r_wd;
    w_err_nxt   = r_err;
    if (valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            w_prev_nxt  = q_in;
            w_state_nxt = S_TRACK;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        S_TRACK: begin
          if (!w_legal) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
          end else if (w_q == w_p) begin
            w_prev_nxt = r_prev;
          end else if (w_q == w_inc) begin
            w_up_nxt   = 1'b1;
            w_dir_nxt  = 1'b1;
            w_prev_nxt = q_in;
            if (r_net != L_NMAX)
              w_net_nxt = r_net + 1'b1;
            if (w_p == L_TOP && r_wu != 8'hFF)
              w_wu_nxt = r_wu + 8'd1;
          end else if (w_q == w_dec) begin
            w_down_nxt = 1'b1;
            w_dir_nxt  = 1'b0;
            w_prev_nxt = q_in;
            if (r_net != L_NMIN)
              w_net_nxt = r_net - 1'b1;
            if (w_p == '0 && r_wd != 8'hFF)
              w_wd_nxt = r_wd + 8'd1;
          end else begin
`ifdef MOD9_TRACK_STRICT_EN
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FAULT;
`else
            w_jump_nxt = 1'b1;
            w_prev_nxt = q_in;
`endif
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and accumulator registers; rst and clr both restore reset values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_jump  <= 1'b0;
      r_dir   <= 1'b1;
      r_net   <= '0;
      r_wu    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_up    <= w_up_nxt;
      r_down  <= w_down_nxt;
      r_jump  <= w_jump_nxt;
      r_dir   <= w_dir_nxt;
      r_net   <= w_net_nxt;
      r_wu    <= w_wu_nxt;
      r_wd    <= w_wd_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign up         = r_up;
  assign down       = r_down;
  assign jump       = r_jump;
  assign dir        = r_dir;
  assign locked     = (r_state == S_TRACK);
  assign net        = r_net;
  assign wraps_up   = r_wu;
  assign wraps_down = r_wd;
  assign err        = r_err;

endmodule

// File: tb/tb_mod9_count_tracker.sv
// tb_mod9_count_tracker: random and directed stimulus against a
// behavioural model of the mod-9 tracker.
module tb_mod9_count_tracker;

  localparam int MOD = 9;

  logic        clk = 1'b0;
  logic        rst, clr, valid;
  logic [3:0]  q_in;
  logic        up, down, jump, dir, locked, err;
  logic signed [15:0] net;
  logic [7:0]  wraps_up, wraps_down;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int m_st;   // 0 idle, 1 track, 2 fault
  int m_prev, m_net, m_wu, m_wd;
  int m_dir, m_err, m_up, m_dn, m_jp;

  mod9_count_tracker #(.MOD(9), .CNT_W(4), .NET_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .valid(valid), .q_in(q_in),
    .up(up), .down(down), .jump(jump), .dir(dir), .locked(locked),
    .net(net), .wraps_up(wraps_up), .wraps_down(wraps_down),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_st = 0; m_prev = 0; m_net = 0; m_wu = 0; m_wd = 0;
    m_dir = 1; m_err = 0; m_up = 0; m_dn = 0; m_jp = 0;
  endtask

  task automatic m_apply(input bit r, input bit c,
                         input bit v, input int q);
    m_up = 0; m_dn = 0; m_jp = 0;
    if (r || c) begin
      m_reset();
    end else if (v) begin
      if (m_st == 0) begin
        if (q < MOD) begin m_prev = q; m_st = 1; end
        else m_err = 1;
      end else if (m_st == 1) begin
        if (q >= MOD) begin
          m_err = 1; m_st = 2;
        end else if (q == m_prev) begin
          m_st = 1;
        end else if (q == (m_prev + 1) % MOD) begin
          m_up = 1; m_dir = 1;
          if (m_net < 32767) m_net++;
          if (m_prev == MOD - 1 && m_wu < 255) m_wu++;
          m_prev = q;
        end else if (q == (m_prev + MOD - 1) % MOD) begin
          m_dn = 1; m_dir = 0;
          if (m_net > -32768) m_net--;
          if (m_prev == 0 && m_wd < 255) m_wd++;
          m_prev = q;
        end else begin
`ifdef MOD9_TRACK_STRICT_EN
          m_err = 1; m_st = 2;
`else
          m_jp = 1; m_prev = q;
`endif
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit c,
                      input bit v, input int q);
    @(negedge clk);
    rst = r; clr = c; valid = v; q_in = 4'(q);
    @(posedge clk);
    m_apply(r, c, v, q);
    #1;
    chk("up", int'(up), m_up);
    chk("down", int'(down), m_dn);
    chk("jump", int'(jump), m_jp);
    chk("dir", int'(dir), m_dir);
    chk("locked", int'(locked), int'(m_st == 1));
    chk("net", int'(net), m_net);
    chk("wraps_up", int'(wraps_up), m_wu);
    chk("wraps_down", int'(wraps_down), m_wd);
    chk("err", int'(err), m_err);
  endtask

  initial begin
    int q;
    int k;
    rst = 1'b1; clr = 1'b0; valid = 1'b0; q_in = '0;
    m_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 3);
    chk("rst_dir", int'(dir), 1);
    chk("rst_net", int'(net), 0);

    // count 0..8,0,1
    for (int i = 0; i < 11; i++) step(0, 0, 1, i % 9);
    chk("seq_net", int'(net), 10);
    chk("seq_wu", int'(wraps_up), 1);

    // 0 then 8,7,8
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 8);
    step(0, 0, 1, 7);
    step(0, 0, 1, 8);
    chk("dn_net", int'(net), -1);
    chk("dn_wd", int'(wraps_down), 1);

    // hold then idle cycles
    step(0, 0, 1, 3);
    step(0, 0, 1, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, i);

    // jump then up (strict: fault)
    step(0, 1, 0, 0);
    step(0, 0, 1, 2);
    step(0, 0, 1, 6);
    step(0, 0, 1, 7);

    // illegal value, fault, clear, relock
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 11);
    step(0, 0, 1, 1);
    step(0, 0, 1, 2);
    chk("flt_err", int'(err), 1);
    step(0, 1, 1, 1);
    step(0, 0, 1, 4);
    chk("relock", int'(locked), 1);

    // saturation
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 40000; i++) step(0, 0, 1, i % 9);
    chk("sat_net", int'(net), 32767);
    chk("sat_wu", int'(wraps_up), 255);
    step(1, 0, 1, 1);
    chk("rstv_net", int'(net), 0);
    chk("rstv_wu", int'(wraps_up), 0);

    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 99);
      if (k < 40) q = (m_prev + 1) % MOD;
      else if (k < 70) q = (m_prev + MOD - 1) % MOD;
      else if (k < 80) q = m_prev;
      else if (k < 97) q = $urandom_range(0, MOD - 1);
      else q = $urandom_range(MOD, 15);
      k = $urandom_range(0, 99);
      step(k == 0, k == 1, $urandom_range(0, 3) != 0, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mod9_count_tracker.md
Name: mod9_count_tracker

Overview:
- Observer/decoder for the sampled 4-bit output of a synchronous loadable mod-9 up/down counter.
- Reconstructs the counter's actions from successive samples: step up, step down, wrap, hold, load jump, illegal value.
- Maintains signed net displacement, wrap tallies and a fault state.
- Sits beside the counter in scoreboards and system monitors, consuming q each time the counter is sampled.

Parameters:
MOD, 9, counter modulus; legal values 0..MOD-1; MOD >= 2, MOD <= 2**CNT_W
CNT_W, 4, width of sampled count
NET_W, 16, width of signed net displacement accumulator

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of accumulators, sticky error and state; returns FSM to IDLE
valid  input  1  q_in is a new sample this cycle
q_in  input  CNT_W  sampled counter value
up  output  1  registered pulse: up step decoded
down  output  1  registered pulse: down step decoded
jump  output  1  registered pulse: non-adjacent legal value (load) decoded
dir  output  1  last step direction, 1 = up, 0 = down
locked  output  1  FSM in TRACK
net  output  NET_W  signed, sum of up steps minus down steps
wraps_up  output  8  count of (MOD-1 -> 0) transitions, saturating at 255
wraps_down  output  8  count of (0 -> MOD-1) transitions, saturating at 255
err  output  1  sticky: illegal value (q_in >= MOD) seen

Behaviour:
- Reset values: all outputs 0; dir = 1; FSM = IDLE; prev = 0.
- Priority: rst > clr > valid. clr has the same effect as rst.
- Pulses up/down/jump are high for exactly one cycle, registered on the edge that samples valid. Latency is 1 cycle. They are 0 in any cycle without a decode.
- FSM IDLE:
  - valid with q_in < MOD: prev <= q_in; go TRACK. No pulse; net unchanged.
  - valid with q_in >= MOD: err <= 1; stay IDLE.
- FSM TRACK, on valid, evaluated against prev in this priority order:
  1. q_in >= MOD: err <= 1; go FAULT; prev unchanged; no pulse.
  2. q_in == prev: hold; no pulse; no state change.
  3. q_in == (prev+1) mod MOD: up pulse; dir <= 1; net += 1. If prev == MOD-1, wraps_up += 1.
  4. q_in == (prev+MOD-1) mod MOD: down pulse; dir <= 0; net -= 1. If prev == 0, wraps_down += 1.
  5. Otherwise: jump pulse; net and dir unchanged.
  - In cases 3-5, prev <= q_in.
  - With MOD == 2, rule 3 wins over rule 4.
- FSM FAULT:
  - Ignores valid entirely: no pulses, no accumulator change, locked = 0.
  - Exits only via rst or clr.
- locked = 1 only in TRACK.
- Arithmetic:
  - net saturates at the signed limits +(2**(NET_W-1))-1 and -(2**(NET_W-1)); it never wraps.
  - wrap counters saturate at 255.
  - Modular neighbours are computed without overflow beyond CNT_W+1 bits.
- valid low: all state holds and pulses are 0.
- rst or clr asserted mid-stream, including in the same cycle as valid: the sample is discarded and reset values apply on the next cycle.

Optional Feature:
- Macro: MOD9_TRACK_STRICT_EN.
- Defined: a decoded jump (rule 5) is treated as an error. err <= 1, FSM goes to FAULT, no jump pulse is issued, and prev is unchanged.
- Not defined: jumps are legal loads, handled as in rule 5. The jump port exists in both builds and is tied 0 in the strict build.

Test Plan:
- Reset, then valid samples 0,1,2,...,8,0,1 -> locked from the 2nd cycle; 10 up pulses; net = 10; wraps_up = 1; dir = 1; err = 0.
- From TRACK at 0, samples 8,7,8 -> down, down (wraps_down = 1), then up; net = -1; dir = 1.
- Samples 3 then 3 with valid, then valid low for 5 cycles -> no pulses; net, prev and outputs all unchanged.
- Samples 2 then 6 -> jump pulse; net unchanged. A following 7 gives an up pulse. With MOD9_TRACK_STRICT_EN: err = 1, locked = 0, and the following 7 is ignored.
- Sample 11 in TRACK -> err = 1, FSM = FAULT, later legal samples produce no pulses. Then clr -> err = 0, net = 0, IDLE; sample 4 -> locked.
- 40000 consecutive up steps with NET_W = 16 -> net holds at 32767 and wraps_up holds at 255. rst asserted together with valid -> all outputs 0 on the next cycle.
